sws_sar_ctrl: RTL and testbench
===============================

# sws_sar_ctrl

Successive-approximation (SAR) conversion controller for the sws analog macro. It drives the track/hold switch and the capacitive-DAC code on the analog front end. It resolves the synchronized comparator output bit by bit and presents a WIDTH-bit result with a one-cycle valid strobe to the digital side of the tile. It sits directly upstream of the tile's digital outputs and directly downstream of the analog comparator.

## Interface
Parameters:
- WIDTH, 8, result and DAC code width (4..12)
- SAMPLE_CYCLES, 4, track (sample) phase length in clk cycles (>=1)
- SETTLE_CYCLES, 3, cycles per bit trial (>=3; includes 2-cycle comparator synchronizer)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  conversion request; accepted only in IDLE
- cmp_in  input  1  asynchronous comparator output from analog macro (1 = Vin >= Vdac)
- sample_o  output  1  track/hold switch control (1 = track)
- dac_o  output  WIDTH  DAC trial code to analog macro
- busy_o  output  1  high from accepted start through DONE
- result_o  output  WIDTH  last completed conversion, held until next DONE
- valid_o  output  1  one-cycle strobe, coincident with result_o update

## Operation
- cmp_in passes through a 2-flop synchronizer (cmp_s) before use; never used raw.
- States:
  - IDLE: leave on start=1.
  - SAMPLE: leave after SAMPLE_CYCLES cycles.
  - CONVERT: bit index k from WIDTH-1 down to 0, SETTLE_CYCLES cycles per bit.
  - DONE: one cycle, then unconditionally back to IDLE.
- IDLE: sample_o=0, dac_o=0, busy_o=0. On start=1 go to SAMPLE.
- SAMPLE: sample_o=1, dac_o=0, busy_o=1.
- CONVERT bit k: dac_o = code | (1<<k), where code holds the bits already resolved. On the last cycle of the bit, code[k] <= cmp_s; bits below k remain 0.
- DONE: result_o <= code, valid_o=1, dac_o=0. busy_o stays 1.
- start is ignored outside IDLE, including in the DONE cycle. There is no queuing.
- Reset: all outputs and the internal code register go to 0, state goes to IDLE, synchronizer flops clear. This applies at any time, including mid-conversion. A reset-aborted conversion never raises valid_o.
- Arithmetic is unsigned binary. A cmp_s held at 1 throughout yields all-ones; held at 0 yields 0.

## Timing
- Let edge N be the rising edge that samples start=1 in IDLE.
- sample_o and busy_o are high after edge N. sample_o falls at edge N+SAMPLE_CYCLES.
- The first trial code (1<<(WIDTH-1)) is on dac_o after edge N+SAMPLE_CYCLES.
- The comparator must settle within SETTLE_CYCLES-2 cycles of a dac_o change, because of the synchronizer latency.
- valid_o is high for exactly the one cycle after edge N+SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES; result_o changes at that same edge.
  - Defaults: valid_o high after edge N+28.
- busy_o falls one edge after valid_o rises. The earliest next accepted start is on the edge that follows the fall.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SWS_SAR_AVG_EN defined:
  - Each accepted start runs 4 back-to-back SAMPLE+CONVERT passes, with no IDLE between them.
  - Results accumulate in a WIDTH+2-bit register, cleared at start acceptance.
  - DONE presents acc[WIDTH+1:2] (truncating mean).
  - valid_o after edge N+4*(SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES); defaults: N+112.
  - busy_o stays high across all passes.
- SWS_SAR_AVG_EN undefined: single pass as above. No accumulator or pass counter is synthesized.

## Test plan
Bench comparator model for all scenarios: cmp_in = (vin >= dac_o), defaults for all parameters.

- Basic conversion: vin=0xA5, pulse start -> valid_o one cycle after edge N+28, result_o=0xA5, busy_o low one edge later, dac_o=0 in IDLE.
- Extremes: vin=0x00 -> result_o=0x00; vin=0xFF -> result_o=0xFF. dac_o trial sequence for 0xFF is 0x80, 0xC0, 0xE0, …, 0xFF.
- Start while busy: pulse start at N+10 and in the DONE cycle -> both ignored, exactly one valid_o. A start one cycle after busy_o falls is accepted.
- Reset mid-conversion: assert rst at N+15 for 1 cycle -> all outputs 0 next cycle, no valid_o. A new start gives a correct result.
- Averaging (SWS_SAR_AVG_EN): vin alternates 0x40, 0x41, 0x41, 0x43 per pass -> result_o=0x41 (sum 0x105>>2), valid_o after edge N+112, sample_o pulses 4 times.
- Non-default parameters: WIDTH=10, SAMPLE_CYCLES=1, SETTLE_CYCLES=5, vin=0x2AA -> result_o=0x2AA, valid_o after edge N+51.

Source files
------------

// File: rtl/sws_sar_ctrl.sv
// sws_sar_ctrl: SAR conversion controller with synchronized comparator and registered outputs.
// Define SWS_SAR_AVG_EN to average four back-to-back conversions per start.
module sws_sar_ctrl #(
  parameter int WIDTH = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o
);
  localparam int MX = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam int KW = $clog2(WIDTH);
  localparam logic [CW-1:0] S_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] k, k_n;
  logic [WIDTH-1:0] code, code_n, res_n;
  logic cmp_m, cmp_s, last_pass, bit_end;
  assign bit_end = state == CONVERT && cnt == T_LAST && k == '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    k_n = k;
    code_n = code;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) state_n = SAMPLE;
      end
      SAMPLE: if (cnt == S_LAST) begin
        state_n = CONVERT;
        cnt_n = '0;
        k_n = KW'(WIDTH - 1);
        code_n = '0;
      end
      CONVERT: if (cnt == T_LAST) begin
        cnt_n = '0;
        code_n = code | (WIDTH'(cmp_s) << k);
        if (k == '0) state_n = last_pass ? DONE : SAMPLE;
        else k_n = k - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef SWS_SAR_AVG_EN
  localparam int AW = WIDTH + 2;
  logic [1:0] pass, pass_n;
  logic [AW-1:0] acc, acc_n;
  assign last_pass = pass == 2'd3;
  assign res_n = acc_n[AW-1:2];
  always_comb begin
    pass_n = pass;
    acc_n = acc;
    if (state == IDLE && start) begin
      pass_n = '0;
      acc_n = '0;
    end else if (bit_end) begin
      pass_n = pass + 1'b1;
      acc_n = acc + AW'(code_n);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= '0;
      acc <= '0;
    end else begin
      pass <= pass_n;
      acc <= acc_n;
    end
  end
`else
  assign last_pass = 1'b1;
  assign res_n = code_n;
`endif
  // outputs are registered from next-state values so they align with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      code <= '0;
      cmp_m <= 1'b0;
      cmp_s <= 1'b0;
      sample_o <= 1'b0;
      busy_o <= 1'b0;
      valid_o <= 1'b0;
      dac_o <= '0;
      result_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      k <= k_n;
      code <= code_n;
      cmp_m <= cmp_in;
      cmp_s <= cmp_m;
      sample_o <= state_n == SAMPLE;
      busy_o <= state_n != IDLE;
      valid_o <= state_n == DONE;
      dac_o <= state_n == CONVERT ? code_n | (WIDTH'(1) << k_n) : '0;
      if (state_n == DONE) result_o <= res_n;
    end
  end
endmodule

// File: tb/tb_sws_sar_ctrl.sv
// tb_sws_sar_ctrl: randomized self-checking bench; ideal comparator cmp_in = (vin >= dac_o).
module tb_sws_sar_ctrl;
  localparam int W = 8;
  localparam int S = 4;
  localparam int T = 3;
  localparam int PASS = S + W * T;
`ifdef SWS_SAR_AVG_EN
  localparam int NP = 4;
`else
  localparam int NP = 1;
`endif
  localparam int LAT = NP * PASS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] vin = '0;
  logic cmp_in, sample_o, busy_o, valid_o;
  logic [W-1:0] dac_o, result_o;
  int checks = 0;
  int failures = 0;
  assign cmp_in = vin >= dac_o;
  always #5 clk = ~clk;
  sws_sar_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cmp_in(cmp_in),
    .sample_o(sample_o),
    .dac_o(dac_o),
    .busy_o(busy_o),
    .result_o(result_o),
    .valid_o(valid_o)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [31:0] res);
    chk({tag, "/sample"}, sample_o, 0);
    chk({tag, "/busy"}, busy_o, 0);
    chk({tag, "/valid"}, valid_o, 0);
    chk({tag, "/dac"}, dac_o, 0);
    chk({tag, "/result"}, result_o, res);
  endtask
  // One accepted start; the model predicts every cycle from vin alone: the ideal SAR
  // trial code for bit k is vin's bits above k plus a trial 1 at k, and the result is vin
  // (or the truncated mean of the per-pass vin values when averaging).
  task automatic conv(input logic [3:0][W-1:0] v, input bit busy_starts, input string tag);
    int sum, vp, j, kk, e, res;
    sum = 0;
    for (int p = 0; p < NP; p++) sum += int'(v[p]);
    res = NP == 4 ? sum >> 2 : sum;
    vin = v[0];
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      j = i % PASS;
      vp = int'(v[i / PASS]);
      e = 0;
      if (j >= S) begin
        kk = W - 1 - (j - S) / T;
        e = ((vp >> (kk + 1)) << (kk + 1)) | (1 << kk);
      end
      chk({tag, "/sample"}, sample_o, j < S);
      chk({tag, "/dac"}, dac_o, e);
      chk({tag, "/busy"}, busy_o, 1);
      chk({tag, "/valid_early"}, valid_o, 0);
      if (j == 0) vin = v[i / PASS];
      start = busy_starts && i == 9;
      tick;
      start = 1'b0;
    end
    chk({tag, "/valid"}, valid_o, 1);
    chk({tag, "/result"}, result_o, res);
    chk({tag, "/done_dac"}, dac_o, 0);
    chk({tag, "/done_busy"}, busy_o, 1);
    chk({tag, "/done_sample"}, sample_o, 0);
    start = busy_starts;
    tick;
    start = 1'b0;
    chk_idle({tag, "/after"}, res);
  endtask
  function automatic logic [3:0][W-1:0] rnd();
    logic [3:0][W-1:0] r;
    for (int p = 0; p < 4; p++) r[p] = W'($urandom);
    return r;
  endfunction
  initial begin
    logic [3:0][W-1:0] r;
    repeat (3) tick;
    chk_idle("reset", 0);
    rst = 1'b0;
    tick;
    chk_idle("idle", 0);
    conv({4{8'hA5}}, 1'b0, "basic_a5");
    conv({4{8'h00}}, 1'b0, "zero");
    conv({4{8'hFF}}, 1'b0, "ones");
`ifdef SWS_SAR_AVG_EN
    conv({8'h43, 8'h41, 8'h41, 8'h40}, 1'b0, "avg");
`endif
    conv(rnd(), 1'b1, "busy_start");
    conv(rnd(), 1'b0, "next_start");
    r = rnd();
    vin = r[0];
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (14) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("mid_reset", 0);
    for (int i = 0; i < LAT + 4; i++) begin
      tick;
      chk("mid_reset/no_valid", valid_o, 0);
      chk("mid_reset/no_busy", busy_o, 0);
    end
    conv({4{8'h5A}}, 1'b0, "post_reset");
    for (int n = 0; n < 8; n++) conv(rnd(), 1'b0, "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
